// File: rtl/satd_pkg.sv
// Shared constants, width derivations and FSM encoding for the 8x8 Hadamard block.
package satd_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned IdxW = 3;

  localparam logic [IdxW-1:0] LastIdx = 3'd7;

  // Each 8-point butterfly grows the word by 3 bits; two passes over a WIDTH+1 diff.
  function automatic int unsigned row_w(input int unsigned width);
    return width + 4;
  endfunction

  function automatic int unsigned col_w(input int unsigned width);
    return width + 7;
  endfunction

  typedef enum logic {
    StLoad,
    StEmit
  } state_e;

endpackage

// File: rtl/hadamard_1d8.sv
// Combinational 8-point Walsh-Hadamard butterfly, natural (Sylvester) order.
module hadamard_1d8
  import satd_pkg::*;
#(
  parameter int unsigned InW = 9
) (
  input  logic signed [InW-1:0] x [N],
  output logic signed [InW+2:0] y [N]
);

  logic signed [InW+2:0] s0 [N];
  logic signed [InW+2:0] s1 [N];
  logic signed [InW+2:0] s2 [N];
  logic signed [InW+2:0] s3 [N];

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign s0[i] = {{3{x[i][InW-1]}}, x[i]};
    assign y[i]  = s3[i];
  end

  // Stage s pairs i with i + 2^s: lower index takes a+b, upper takes a-b.
  for (genvar i = 0; i < N; i++) begin : g_st0
    if ((i & 1) == 0) begin : g_sum
      assign s1[i] = s0[i] + s0[i+1];
    end else begin : g_dif
      assign s1[i] = s0[i-1] - s0[i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_st1
    if ((i & 2) == 0) begin : g_sum
      assign s2[i] = s1[i] + s1[i+2];
    end else begin : g_dif
      assign s2[i] = s1[i-2] - s1[i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_st2
    if ((i & 4) == 0) begin : g_sum
      assign s3[i] = s2[i] + s2[i+4];
    end else begin : g_dif
      assign s3[i] = s2[i-4] - s2[i];
    end
  end

endmodule

// File: rtl/hadamard_8x8.sv
// 2-D 8x8 Hadamard (H8 * D * H8): rows transformed on entry into a register
// transpose buffer, columns transformed and emitted one per cycle.
module hadamard_8x8
  import satd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH:0]   diff_0,
  input  logic signed [WIDTH:0]   diff_1,
  input  logic signed [WIDTH:0]   diff_2,
  input  logic signed [WIDTH:0]   diff_3,
  input  logic signed [WIDTH:0]   diff_4,
  input  logic signed [WIDTH:0]   diff_5,
  input  logic signed [WIDTH:0]   diff_6,
  input  logic signed [WIDTH:0]   diff_7,
  output logic                    out_valid,
  output logic                    out_last,
  output logic signed [WIDTH+6:0] coef_0,
  output logic signed [WIDTH+6:0] coef_1,
  output logic signed [WIDTH+6:0] coef_2,
  output logic signed [WIDTH+6:0] coef_3,
  output logic signed [WIDTH+6:0] coef_4,
  output logic signed [WIDTH+6:0] coef_5,
  output logic signed [WIDTH+6:0] coef_6,
  output logic signed [WIDTH+6:0] coef_7
);

  localparam int unsigned RowW = row_w(WIDTH);
  localparam int unsigned ColW = col_w(WIDTH);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     row_cnt_q, row_cnt_d;
  logic [IdxW-1:0]     col_cnt_q, col_cnt_d;
  logic                out_valid_q, out_last_q;
  logic signed [WIDTH:0]  row_in  [N];
  logic signed [RowW-1:0] row_out [N];
  logic signed [RowW-1:0] buf_q   [N][N];
  logic signed [RowW-1:0] buf_d   [N][N];
  logic signed [RowW-1:0] col_in  [N];
  logic signed [ColW-1:0] col_out [N];
  logic signed [ColW-1:0] coef_q  [N];

  assign row_in[0] = diff_0;
  assign row_in[1] = diff_1;
  assign row_in[2] = diff_2;
  assign row_in[3] = diff_3;
  assign row_in[4] = diff_4;
  assign row_in[5] = diff_5;
  assign row_in[6] = diff_6;
  assign row_in[7] = diff_7;

  hadamard_1d8 #(.InW(WIDTH + 1)) u_row (
    .x (row_in),
    .y (row_out)
  );

  hadamard_1d8 #(.InW(RowW)) u_col (
    .x (col_in),
    .y (col_out)
  );

  assign in_ready = (state_q == StLoad);

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    buf_d     = buf_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          buf_d[row_cnt_q] = row_out;
          if (row_cnt_q == LastIdx) begin
            state_d   = StEmit;
            row_cnt_d = '0;
            col_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end
      end
      StEmit: begin
        col_cnt_d = col_cnt_q + 3'd1;
        if (col_cnt_q == LastIdx) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Column source looks ahead at next-state buffer/index so the registered
  // coefficients line up with the EMIT cycle that owns them.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      col_in[r] = buf_d[r][col_cnt_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        coef_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= (state_d == StEmit);
      out_last_q  <= (state_d == StEmit) && (col_cnt_d == LastIdx);
      if (state_d == StEmit) begin
        coef_q <= col_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q <= buf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign coef_0    = coef_q[0];
  assign coef_1    = coef_q[1];
  assign coef_2    = coef_q[2];
  assign coef_3    = coef_q[3];
  assign coef_4    = coef_q[4];
  assign coef_5    = coef_q[5];
  assign coef_6    = coef_q[6];
  assign coef_7    = coef_q[7];

endmodule

// File: tb/tb_hadamard_8x8.sv
// Directed and randomised checks of hadamard_8x8 against a matrix-product model.
module tb_hadamard_8x8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, out_last;
  logic signed [8:0]  drv  [8];
  logic signed [14:0] coef [8];

  int checks = 0;
  int errors = 0;
  int blk   [8][8];
  int exp_c [8][8];
  int got   [8][8];
  bit got_last [8];
  bit got_valid[8];
  bit got_ready[8];
  int lat;

  always #5 clk = ~clk;

  hadamard_8x8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .diff_0   (drv[0]),
    .diff_1   (drv[1]),
    .diff_2   (drv[2]),
    .diff_3   (drv[3]),
    .diff_4   (drv[4]),
    .diff_5   (drv[5]),
    .diff_6   (drv[6]),
    .diff_7   (drv[7]),
    .out_valid(out_valid),
    .out_last (out_last),
    .coef_0   (coef[0]),
    .coef_1   (coef[1]),
    .coef_2   (coef[2]),
    .coef_3   (coef[3]),
    .coef_4   (coef[4]),
    .coef_5   (coef[5]),
    .coef_6   (coef[6]),
    .coef_7   (coef[7])
  );

  function automatic int hs(input int i, input int j);
    return ($countones(i & j) % 2 == 1) ? -1 : 1;
  endfunction

  // exp_c[m][k] = sum_r sum_j H[m][r] * D[r][j] * H[j][k]
  task automatic model();
    for (int m = 0; m < 8; m++) begin
      for (int k = 0; k < 8; k++) begin
        int acc;
        acc = 0;
        for (int r = 0; r < 8; r++) begin
          for (int j = 0; j < 8; j++) begin
            acc += hs(m, r) * blk[r][j] * hs(j, k);
          end
        end
        exp_c[m][k] = acc;
      end
    end
  endtask

  task automatic set_junk(input int seed);
    for (int j = 0; j < 8; j++) drv[j] = 9'(j * 13 - 50 + seed);
  endtask

  task automatic drive_row(input int r);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    for (int j = 0; j < 8; j++) drv[j] = 9'(blk[r][j]);
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL row_accept row=%0d in_ready=%b want 1", r, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input bit stall, input bit hold);
    for (int r = 0; r < 8; r++) begin
      if (stall && (r % 2 == 1)) begin
        @(negedge clk);
        in_valid = 1'b0;
        set_junk(r);
        @(posedge clk);
        #1;
      end
      drive_row(r);
    end
    if (hold) set_junk(33);
    else in_valid = 1'b0;
  endtask

  task automatic capture();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      got_valid[k] = out_valid;
      got_last[k]  = out_last;
      got_ready[k] = in_ready;
      for (int m = 0; m < 8; m++) got[k][m] = int'(coef[m]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) drv[j] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_last got %b want 0", out_last);
    end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (coef[m] !== 15'sd0) begin
        errors++; $display("FAIL reset_coef m=%0d got %0d want 0", m, coef[m]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_all_ones();
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = 1;
    drive_block(1'b0, 1'b0);
    capture();
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL ones_latency got %0d want 1", lat);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_valid[k] !== 1'b1 || got_ready[k] !== 1'b0 || got_last[k] !== (k == 7)) begin
        errors++;
        $display("FAIL ones_flags beat=%0d valid=%b ready=%b last=%b want 1 0 %b",
                 k, got_valid[k], got_ready[k], got_last[k], k == 7);
      end
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[k][m] !== ((k == 0 && m == 0) ? 64 : 0)) begin
          errors++;
          $display("FAIL ones_coef col=%0d row=%0d got %0d want %0d", k, m, got[k][m],
                   (k == 0 && m == 0) ? 64 : 0);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ones_after valid=%b last=%b ready=%b want 0 0 1",
               out_valid, out_last, in_ready);
    end
  endtask

  task automatic test_single_dc();
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = 0;
    blk[0][0] = 5;
    drive_block(1'b0, 1'b0);
    capture();
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[k][m] !== 5) begin
          errors++;
          $display("FAIL dc5_coef col=%0d row=%0d got %0d want 5", k, m, got[k][m]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    for (int pass = 0; pass < 2; pass++) begin
      int v;
      v = (pass == 0) ? 255 : -255;
      for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = v;
      drive_block(1'b0, 1'b0);
      capture();
      for (int k = 0; k < 8; k++) begin
        for (int m = 0; m < 8; m++) begin
          checks++;
          if (got[k][m] !== ((k == 0 && m == 0) ? 64 * v : 0)) begin
            errors++;
            $display("FAIL extreme v=%0d col=%0d row=%0d got %0d want %0d", v, k, m,
                     got[k][m], (k == 0 && m == 0) ? 64 * v : 0);
          end
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    int ready_hi;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) blk[r][j] = ((r * 37 + j * 11) % 200) - 100;
    model();
    drive_block(1'b1, 1'b1);
    capture();
    ready_hi = 0;
    for (int k = 0; k < 8; k++) if (got_ready[k]) ready_hi++;
    checks++;
    if (ready_hi !== 0) begin
      errors++; $display("FAIL stall_ready_in_emit got %0d cycles want 0", ready_hi);
    end
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[k][m] !== exp_c[m][k]) begin
          errors++;
          $display("FAIL stall_coef col=%0d row=%0d got %0d want %0d", k, m, got[k][m],
                   exp_c[m][k]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_valid got %b want 0", out_valid);
    end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (int'(coef[m]) !== exp_c[m][7]) begin
        errors++;
        $display("FAIL hold_coef row=%0d got %0d want %0d", m, coef[m], exp_c[m][7]);
      end
    end
    // Rows offered during EMIT must not have leaked into this block.
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = (r - j) * 20;
    model();
    drive_block(1'b0, 1'b0);
    capture();
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[k][m] !== exp_c[m][k]) begin
          errors++;
          $display("FAIL after_hold_coef col=%0d row=%0d got %0d want %0d", k, m,
                   got[k][m], exp_c[m][k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = 90 - r * 7 - j;
    for (int r = 0; r < 5; r++) drive_row(r);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    set_junk(7);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_during valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_after valid=%b want 0", out_valid);
    end
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) blk[r][j] = (r * 3 + j * 5) - 40;
    model();
    drive_block(1'b0, 1'b0);
    capture();
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[k][m] !== exp_c[m][k]) begin
          errors++;
          $display("FAIL midreset_coef col=%0d row=%0d got %0d want %0d", k, m,
                   got[k][m], exp_c[m][k]);
        end
      end
    end
    // Reset in the middle of EMIT drops the remaining columns.
    drive_block(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL emitreset valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int b = 0; b < 1000; b++) begin
      for (int r = 0; r < 8; r++)
        for (int j = 0; j < 8; j++) blk[r][j] = int'($urandom_range(510)) - 255;
      model();
      drive_block(b % 7 == 3, 1'b0);
      capture();
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL rand_latency blk=%0d got %0d want 1", b, lat);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_valid[k] !== 1'b1 || got_last[k] !== (k == 7)) begin
          errors++;
          $display("FAIL rand_flags blk=%0d beat=%0d valid=%b last=%b want 1 %b",
                   b, k, got_valid[k], got_last[k], k == 7);
        end
        for (int m = 0; m < 8; m++) begin
          checks++;
          if (got[k][m] !== exp_c[m][k]) begin
            errors++;
            $display("FAIL rand_coef blk=%0d col=%0d row=%0d got %0d want %0d",
                     b, k, m, got[k][m], exp_c[m][k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_dc();
    test_extremes();
    test_stall_hold();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
